// File: rtl/game_ctrl.sv
// Round sequencer for the space-shooter game: state, score, frame timer, LEDs.
// Gates ship motion/firing and restores obstacles at the start of each round.
module game_ctrl #(
    parameter int N_OBS       = 8,
    parameter int TIME_LIMIT  = 1800,
    parameter int TW          = 11,
    parameter int HOLD_FRAMES = 180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             fire,
    input  logic [N_OBS-1:0] obs_alive,
    output logic             obs_clear,
    output logic             play_en,
    output logic [2:0]       state,
    output logic [7:0]       score,
    output logic [TW-1:0]    time_left,
    output logic [7:0]       leds
);

    localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_PLAY = 3'd2;
    localparam logic [2:0] S_WIN  = 3'd3;
    localparam logic [2:0] S_LOSE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             fire_q;
    logic [N_OBS-1:0] alive_q;
    logic [7:0]       score_q, score_d;
    logic [TW-1:0]    time_q, time_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [7:0]       leds_q, leds_d;

    logic             start;
    logic             all_up;
    logic             all_down;
    logic [N_OBS-1:0] hits;
    logic [3:0]       nhits;
    logic [8:0]       sum;

    assign start    = fire & ~fire_q;
    assign all_up   = &obs_alive;
    assign all_down = ~|obs_alive;
    assign hits     = alive_q & ~obs_alive;

    always_comb begin
        nhits = '0;
        for (int i = 0; i < N_OBS; i++) begin
            nhits = nhits + 4'(hits[i]);
        end
    end

    assign sum = {1'b0, score_q} + 9'(nhits);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            fire_q  <= 1'b0;
            alive_q <= '0;
            score_q <= '0;
            time_q  <= '0;
            hold_q  <= '0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            fire_q  <= fire;
            alive_q <= obs_alive;
            score_q <= score_d;
            time_q  <= time_d;
            hold_q  <= hold_d;
            leds_q  <= leds_d;
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        time_d  = time_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                hold_d = '0;
                if (start) begin
                    score_d = '0;
                    time_d  = TW'(TIME_LIMIT);
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (all_up) state_d = S_PLAY;
            end
            S_PLAY: begin
                score_d = sum[8] ? 8'hFF : sum[7:0];
                hold_d  = '0;
                // Clearing the field wins over a timeout in the same cycle.
                if (all_down) begin
                    state_d = S_WIN;
                end else if (frame_tick) begin
                    if (time_q == TW'(1)) begin
                        time_d  = '0;
                        state_d = S_LOSE;
                    end else begin
                        time_d = time_q - TW'(1);
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (frame_tick) begin
                    if (hold_q == HW'(HOLD_FRAMES - 1)) begin
                        hold_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        obs_clear = (state_q == S_ARM);
        play_en   = (state_q == S_PLAY);
        case (state_d)
            S_PLAY:  leds_d = 8'(obs_alive);
            S_WIN:   leds_d = 8'hFF;
            S_LOSE:  leds_d = 8'hAA;
            default: leds_d = 8'h00;
        endcase
    end

    assign state     = state_q;
    assign score     = score_q;
    assign time_left = time_q;
    assign leds      = leds_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: cycle vectors for full rounds plus a
// hand-written mid-round reset sequence.
module tb_game_ctrl;

    localparam int N_OBS = 8;
    localparam int TL    = 5;
    localparam int TW    = 11;
    localparam int HOLD  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             frame_tick;
    logic             fire;
    logic [N_OBS-1:0] obs_alive;
    logic             obs_clear;
    logic             play_en;
    logic [2:0]       state;
    logic [7:0]       score;
    logic [TW-1:0]    time_left;
    logic [7:0]       leds;

    int n_run  = 0;
    int n_fail = 0;

    game_ctrl #(
        .N_OBS(N_OBS), .TIME_LIMIT(TL), .TW(TW), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .fire(fire),
        .obs_alive(obs_alive), .obs_clear(obs_clear), .play_en(play_en),
        .state(state), .score(score), .time_left(time_left), .leds(leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       fire;
        logic [7:0] alive;
        logic       tick;
        logic [2:0] st;
        logic       clr;
        logic       pen;
        logic [7:0] sc;
        int         tl;
        logic [7:0] led;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic f, input logic [7:0] a,
                       input logic t, input logic [2:0] st, input logic clr,
                       input logic pen, input logic [7:0] sc, input int tl,
                       input logic [7:0] led);
        vec_t v;
        v.nm = nm; v.fire = f; v.alive = a; v.tick = t;
        v.st = st; v.clr = clr; v.pen = pen; v.sc = sc; v.tl = tl; v.led = led;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [2:0] st,
                           input logic clr, input logic pen,
                           input logic [7:0] sc, input int tl,
                           input logic [7:0] led);
        chk({nm, ".state"}, int'(state), int'(st));
        chk({nm, ".obs_clear"}, int'(obs_clear), int'(clr));
        chk({nm, ".play_en"}, int'(play_en), int'(pen));
        chk({nm, ".score"}, int'(score), int'(sc));
        chk({nm, ".time_left"}, int'(time_left), tl);
        chk({nm, ".leds"}, int'(leds), int'(led));
    endtask

    task automatic step(input logic f, input logic [7:0] a, input logic t);
        fire = f; obs_alive = a; frame_tick = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // name, fire, alive, tick | state, clr, pen, score, time, leds
        add("idle",     0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
        add("start",    1, 8'h00, 0, 1, 1, 0, 0, 5, 8'h00);
        add("arm_wait", 0, 8'h00, 0, 1, 1, 0, 0, 5, 8'h00);
        add("arm_full", 0, 8'hFF, 0, 2, 0, 1, 0, 5, 8'hFF);
        add("tick1",    0, 8'hFF, 1, 2, 0, 1, 0, 4, 8'hFF);
        add("hit0",     0, 8'hFE, 0, 2, 0, 1, 1, 4, 8'hFE);
        add("hit1",     0, 8'hFC, 0, 2, 0, 1, 2, 4, 8'hFC);
        add("hit34",    0, 8'hE4, 0, 2, 0, 1, 4, 4, 8'hE4);
        add("fire_ply", 1, 8'hE4, 0, 2, 0, 1, 4, 4, 8'hE4);
        add("hit_tick", 0, 8'hE0, 1, 2, 0, 1, 5, 3, 8'hE0);
        add("hit6",     0, 8'hC0, 0, 2, 0, 1, 6, 3, 8'hC0);
        add("hit7",     0, 8'h80, 0, 2, 0, 1, 7, 3, 8'h80);
        add("win",      0, 8'h00, 1, 3, 0, 0, 8, 3, 8'hFF);
        add("win_f1",   1, 8'h00, 1, 3, 0, 0, 8, 3, 8'hFF);
        add("win_f2",   1, 8'h00, 0, 3, 0, 0, 8, 3, 8'hFF);
        add("win_done", 1, 8'h00, 1, 0, 0, 0, 8, 3, 8'h00);
        add("held",     1, 8'h00, 0, 0, 0, 0, 8, 3, 8'h00);
        add("release",  0, 8'h00, 0, 0, 0, 0, 8, 3, 8'h00);
        add("restart",  1, 8'h00, 0, 1, 1, 0, 0, 5, 8'h00);
        add("arm_part", 0, 8'h7F, 0, 1, 1, 0, 0, 5, 8'h00);
        add("play2",    0, 8'hFF, 0, 2, 0, 1, 0, 5, 8'hFF);
        add("to_t4",    0, 8'hFF, 1, 2, 0, 1, 0, 4, 8'hFF);
        add("to_fire",  1, 8'hFF, 0, 2, 0, 1, 0, 4, 8'hFF);
        add("to_t3",    0, 8'hFF, 1, 2, 0, 1, 0, 3, 8'hFF);
        add("to_t2",    0, 8'hFF, 1, 2, 0, 1, 0, 2, 8'hFF);
        add("to_t1",    0, 8'hFF, 1, 2, 0, 1, 0, 1, 8'hFF);
        add("lose",     0, 8'h7F, 1, 4, 0, 0, 1, 0, 8'hAA);
        add("lose_frz", 1, 8'h00, 0, 4, 0, 0, 1, 0, 8'hAA);
        add("lose_h1",  0, 8'h00, 1, 4, 0, 0, 1, 0, 8'hAA);
        add("lose_end", 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00);
        add("start3",   1, 8'h00, 0, 1, 1, 0, 0, 5, 8'h00);
        add("play3",    0, 8'hFF, 0, 2, 0, 1, 0, 5, 8'hFF);
        add("s_t4",     0, 8'hFF, 1, 2, 0, 1, 0, 4, 8'hFF);
        add("s_t3",     0, 8'hFF, 1, 2, 0, 1, 0, 3, 8'hFF);
        add("s_t2",     0, 8'hFF, 1, 2, 0, 1, 0, 2, 8'hFF);
        add("s_t1",     0, 8'hFF, 1, 2, 0, 1, 0, 1, 8'hFF);
        add("sim_win",  0, 8'h00, 1, 3, 0, 0, 8, 1, 8'hFF);
        add("sim_h1",   0, 8'h00, 1, 3, 0, 0, 8, 1, 8'hFF);
        add("sim_end",  0, 8'h00, 1, 0, 0, 0, 8, 1, 8'h00);

        reset = 1'b1; fire = 1'b0; frame_tick = 1'b0; obs_alive = '0;
        #3;
        chk_all("rst", 0, 0, 0, 0, 0, 8'h00);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].fire, vecs[i].alive, vecs[i].tick);
            chk_all(vecs[i].nm, vecs[i].st, vecs[i].clr, vecs[i].pen,
                    vecs[i].sc, vecs[i].tl, vecs[i].led);
        end

        // Reset mid-round with score 3, then a fresh round from zero.
        step(1, 8'h00, 0);
        step(0, 8'hFF, 0);
        step(0, 8'hFE, 0);
        step(0, 8'hFC, 0);
        step(0, 8'hF8, 0);
        chk_all("pre_rst", 2, 0, 1, 3, 5, 8'hF8);
        #2 reset = 1'b1;
        #1;
        chk_all("mid_rst", 0, 0, 0, 0, 0, 8'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        step(0, 8'hFF, 0);
        chk_all("post_idle", 0, 0, 0, 0, 0, 8'h00);
        step(1, 8'hFF, 0);
        chk_all("post_arm", 1, 1, 0, 0, 5, 8'h00);
        step(0, 8'hFF, 0);
        chk_all("post_play", 2, 0, 1, 0, 5, 8'hFF);
        step(0, 8'hEF, 0);
        chk_all("post_hit", 2, 0, 1, 1, 5, 8'hEF);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Round sequencer for the space-shooter VGA game. It owns the game state (idle, arming, playing, won, lost) and restores the obstacle row at the start of each round. It gates ship movement and firing, counts down a per-round frame timer, tallies destroyed obstacles into a score, and drives the board LEDs. It sits beside the wall/ship and obstacle blocks and consumes their per-obstacle alive flags plus the frame tick from the sync generator.

## Interface

Parameters:
- N_OBS, 8: number of obstacles; legal range 1..8.
- TIME_LIMIT, 1800: round length in frames (30 s at 60 Hz); must be ≥1 and fit in TW bits.
- TW, 11: width of time_left.
- HOLD_FRAMES, 180: frames the WIN/LOSE screen is held before returning to IDLE; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- frame_tick  in  1  one-cycle pulse per frame, synchronous to clk.
- fire  in  1  fire button level, already synchronized to clk.
- obs_alive  in  N_OBS  bit i = 1 while obstacle i is still standing.
- obs_clear  out  1  high while in ARM; obstacles restore themselves while it is high.
- play_en  out  1  high only in PLAY; gates ship motion and bullet launch.
- state  out  3  0=IDLE, 1=ARM, 2=PLAY, 3=WIN, 4=LOSE.
- score  out  8  obstacles destroyed this round; saturates at 255.
- time_left  out  TW  frames remaining in the round.
- leds  out  8  status LEDs, registered.

## Operation

- The block registers fire once (fire_q). start = fire & ~fire_q, a rising edge. start is honoured only in IDLE.
- The block registers obs_alive every cycle (alive_q). hits = alive_q & ~obs_alive, the falling bits.
- IDLE: obs_clear=0 and play_en=0. On start: score←0, time_left←TIME_LIMIT, go to ARM.
- ARM: obs_clear=1. Hit detection is disabled. When obs_alive == all ones, go to PLAY. ARM has no timeout: it waits indefinitely.
- PLAY: play_en=1.
  - Each cycle: score ← min(255, score + popcount(hits)).
  - If obs_alive == 0: go to WIN. This takes priority over everything else in the same cycle, and time_left is not decremented in that cycle.
  - Otherwise, on frame_tick: if time_left == 1, set time_left←0 and go to LOSE; else time_left←time_left−1.
  - start is ignored.
- WIN / LOSE: play_en=0. score and time_left are frozen. A hold counter resets to 0 on entry and increments on each frame_tick. When it reaches HOLD_FRAMES, go to IDLE. start is ignored.
- A hit in the same cycle as the timeout tick is still scored, and the block goes to LOSE unless obs_alive == 0.
- leds:
  - IDLE/ARM: 8'h00.
  - PLAY: zero-extended obs_alive.
  - WIN: 8'hFF.
  - LOSE: 8'hAA.
- Unused state encodings (5–7) return to IDLE on the next clock.

## Timing

- Every output is a register, or decoded from registers only. No input reaches an output combinationally.
- Reset values: state=IDLE, obs_clear=0, play_en=0, score=0, time_left=0, leds=8'h00. Internal fire_q, alive_q and hold counter are all 0.
- Reset mid-round takes effect immediately, asynchronously. obs_clear drops at once and the next round needs a new start edge.
- start sampled at edge N: state=ARM and obs_clear=1 from edge N+1.
- obs_alive full at edge M while in ARM: PLAY and play_en=1 from edge M+1, obs_clear=0 from edge M+1.
- A falling obs_alive bit at edge K in PLAY: score is updated at edge K+1.
- obs_alive==0 sampled at edge K: state=WIN at K+1.
- A fire level held high across IDLE entry does not start a round; a fresh rising edge is required.

## Test plan

- **Basic start:** reset, raise fire for 1 cycle, obs_alive=8'hFF two cycles later.
  - obs_clear high for exactly the cycles in ARM.
  - PLAY one cycle after obs_alive full.
  - time_left=TIME_LIMIT, score=0.
- **Win (TIME_LIMIT=5):** in PLAY, drop obstacles one bit per frame, with bits 3 and 4 dropping in the same cycle.
  - score steps 1,2,4,…,8.
  - WIN one cycle after obs_alive==0, leds=8'hFF.
  - time_left frozen.
- **Timeout (TIME_LIMIT=5, HOLD_FRAMES=2):** in PLAY, 5 frame_ticks with no hits.
  - time_left 5→0, LOSE on the 5th tick, leds=8'hAA.
  - IDLE after 2 further ticks.
- **Simultaneous:** last obstacle falls in the same cycle as the time_left==1 tick → WIN, time_left stays 1.
- **Ignored inputs:** fire edges in PLAY/WIN/LOSE cause no state change; fire held high through return to IDLE does not restart until released and pressed again.
- **Reset mid-round:** assert reset in PLAY with score=3.
  - All outputs return to reset values asynchronously.
  - A new start edge runs a normal round with score from 0.
